// File: rtl/stage2_instr_decoder_if.sv
// Handshake bundle between fetch, the decode stage and execute.
// Carries the fetch-side word, the decoded word and the redirect path.
interface stage2_instr_decoder_if #(
  parameter int PC_W      = 10,
  parameter int REG_IDX_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_instr1;
  logic [7:0]           in_instr2;
  logic [7:0]           in_instr3;
  logic [7:0]           in_instr4;
  logic [PC_W-1:0]      in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           out_class;
  logic [2:0]           out_func;
  logic [REG_IDX_W-1:0] out_rd;
  logic [REG_IDX_W-1:0] out_rs;
  logic [15:0]          out_imm;
  logic [PC_W-1:0]      out_pc;
  logic                 redirect_valid;
  logic [PC_W-1:0]      redirect_pc;
  logic                 halted;

  modport master (
    output in_valid, in_instr1, in_instr2,
    output in_instr3, in_instr4, in_pc,
    output out_ready,
    input  in_ready, out_valid, out_class,
    input  out_func, out_rd, out_rs, out_imm,
    input  out_pc, redirect_valid,
    input  redirect_pc, halted
  );

  modport slave (
    input  in_valid, in_instr1, in_instr2,
    input  in_instr3, in_instr4, in_pc,
    input  out_ready,
    output in_ready, out_valid, out_class,
    output out_func, out_rd, out_rs, out_imm,
    output out_pc, redirect_valid,
    output redirect_pc, halted
  );
endinterface

// File: rtl/stage2_instr_decoder.sv
// Decode stage: 2-entry skid FIFO, decoder, output register.
// JMP is resolved here as a fetch redirect; HALT stops intake.
module stage2_instr_decoder #(
  parameter int PC_W      = 10,
  parameter int REG_IDX_W = 5
) (
  input  logic clk,
  input  logic rst,
  stage2_instr_decoder_if.slave bus
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ALU  = 8'h01;
  localparam logic [7:0] OP_LDI  = 8'h02;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_JZ   = 8'h11;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam logic [2:0] CLS_NOP  = 3'd0;
  localparam logic [2:0] CLS_ALU  = 3'd1;
  localparam logic [2:0] CLS_LDI  = 3'd2;
  localparam logic [2:0] CLS_JZ   = 3'd3;
  localparam logic [2:0] CLS_HALT = 3'd4;
  localparam logic [2:0] CLS_ILL  = 3'd7;

  typedef struct packed {
    logic [7:0]      b1;
    logic [7:0]      b2;
    logic [7:0]      b3;
    logic [7:0]      b4;
    logic [PC_W-1:0] pc;
  } entry_t;

  typedef struct packed {
    logic [2:0]           cls;
    logic [2:0]           func;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs;
    logic [15:0]          imm;
    logic [PC_W-1:0]      pc;
  } dec_t;

  function automatic dec_t decode(entry_t e);
    dec_t d;
    d.func = e.b2[7:5];
    d.rd   = e.b2[REG_IDX_W-1:0];
    d.rs   = e.b3[REG_IDX_W-1:0];
    d.imm  = {e.b3, e.b4};
    d.pc   = e.pc;
    unique case (1'b1)
      (e.b1 == OP_NOP):  d.cls = CLS_NOP;
      (e.b1 == OP_ALU):  d.cls = CLS_ALU;
      (e.b1 == OP_LDI):  d.cls = CLS_LDI;
      (e.b1 == OP_JZ):   d.cls = CLS_JZ;
      (e.b1 == OP_HALT): d.cls = CLS_HALT;
      default:           d.cls = CLS_ILL;
    endcase
    return d;
  endfunction

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  dec_t       out_q, out_d;
  logic       halted_q, halted_d;
  logic       live_q, live_d;

  entry_t in_e;
  entry_t head;
  logic   empty, full, head_jmp;
  logic   halt_hs, adv, redirect;
  logic   in_ready, push, bypass;
  logic   wr_en, pop_load, flush;

  assign in_e = '{b1: bus.in_instr1, b2: bus.in_instr2,
                  b3: bus.in_instr3, b4: bus.in_instr4,
                  pc: bus.in_pc};
  assign head = mem_q[rd_ptr_q];

  // Handshake and flow-control decisions for this cycle.
  always_comb begin
    empty    = (cnt_q == 2'd0);
    full     = (cnt_q == 2'd2);
    head_jmp = !empty && (head.b1 == OP_JMP);
    halt_hs  = out_valid_q && bus.out_ready &&
               (out_q.cls == CLS_HALT);
    adv      = live_q && !halted_q && !halt_hs &&
               (!out_valid_q || bus.out_ready);
    redirect = adv && head_jmp;
    in_ready = live_q && !full && !halted_q && !redirect;
    push     = bus.in_valid && in_ready;
    bypass   = adv && empty && push && (in_e.b1 != OP_JMP);
    wr_en    = push && !bypass;
    pop_load = adv && !empty && !head_jmp;
    flush    = redirect || halt_hs;
  end

  // Skid FIFO bookkeeping; a JMP or HALT drops younger words.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = in_e;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_load) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + 2'(wr_en) - 2'(pop_load);
    end
  end

  // Output register: refill from FIFO head or straight from input.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    halted_d    = halted_q || halt_hs;
    live_d      = 1'b1;
    if (halt_hs) begin
      out_valid_d = 1'b0;
    end else if (adv) begin
      out_valid_d = pop_load || bypass;
      if (pop_load)    out_d = decode(head);
      else if (bypass) out_d = decode(in_e);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q       <= '{default: '0};
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      halted_q    <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      halted_q    <= halted_d;
      live_q      <= live_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_class      = out_q.cls;
  assign bus.out_func       = out_q.func;
  assign bus.out_rd         = out_q.rd;
  assign bus.out_rs         = out_q.rs;
  assign bus.out_imm        = out_q.imm;
  assign bus.out_pc         = out_q.pc;
  assign bus.redirect_valid = redirect;
  assign bus.redirect_pc    = redirect ?
                              PC_W'({head.b3, head.b4}) : '0;
  assign bus.halted         = halted_q;

endmodule

// File: tb/tb_stage2_instr_decoder.sv
// Bench for stage2_instr_decoder: directed scenarios plus random
// traffic checked against an in-order event scoreboard.
module tb_stage2_instr_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage2_instr_decoder_if bus ();

  stage2_instr_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [7:0] b4;
    logic [9:0] pc;
  } word_t;

  typedef struct packed {
    logic       redir;
    logic [2:0] cls;
    logic [2:0] func;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [15:0] imm;
    logic [9:0] pc;
  } item_t;

  word_t src[$];
  item_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit presented, m_jmp, m_haltacc, m_halted;
  int vmode, rmode;
  int acc_cnt, hs_cnt, rd_cnt;
  int first_acc, first_ov, first_hs, last_hs;
  bit stall_prev;
  item_t prev_obs;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(logic [7:0] a, logic [7:0] b,
                               logic [7:0] c, logic [7:0] d,
                               logic [9:0] pc);
    word_t w;
    w.b1 = a; w.b2 = b; w.b3 = c; w.b4 = d; w.pc = pc;
    return w;
  endfunction

  function automatic item_t ref_out(word_t w);
    item_t it;
    int op;
    op = int'(w.b1);
    it = '0;
    if (op == 0) it.cls = 3'd0;
    else if (op == 1) it.cls = 3'd1;
    else if (op == 2) it.cls = 3'd2;
    else if (op == 17) it.cls = 3'd3;
    else if (op == 255) it.cls = 3'd4;
    else it.cls = 3'd7;
    it.func = 3'(int'(w.b2) / 32);
    it.rd   = 5'(int'(w.b2) % 32);
    it.rs   = 5'(int'(w.b3) % 32);
    it.imm  = 16'(int'(w.b3) * 256 + int'(w.b4));
    it.pc   = w.pc;
    return it;
  endfunction

  function automatic item_t ref_redir(word_t w);
    item_t it;
    it = '0;
    it.redir = 1'b1;
    it.pc = 10'((int'(w.b3) * 256 + int'(w.b4)) % 1024);
    return it;
  endfunction

  function automatic item_t obs_item();
    item_t o;
    o.redir = 1'b0;
    o.cls   = bus.out_class;
    o.func  = bus.out_func;
    o.rd    = bus.out_rd;
    o.rs    = bus.out_rs;
    o.imm   = bus.out_imm;
    o.pc    = bus.out_pc;
    return o;
  endfunction

  task automatic model_accept(word_t w);
    if (m_haltacc || m_jmp) return;
    if (w.b1 == 8'h10) begin
      exp_q.push_back(ref_redir(w));
      m_jmp = 1'b1;
    end else begin
      exp_q.push_back(ref_out(w));
      if (w.b1 == 8'hFF) m_haltacc = 1'b1;
    end
  endtask

  task automatic drive();
    if (!presented && src.size() > 0 &&
        (vmode == 1 || $urandom_range(0, 3) != 0))
      presented = 1'b1;
    bus.in_valid = presented;
    if (presented) begin
      bus.in_instr1 = src[0].b1;
      bus.in_instr2 = src[0].b2;
      bus.in_instr3 = src[0].b3;
      bus.in_instr4 = src[0].b4;
      bus.in_pc     = src[0].pc;
    end
    if (rmode == 2) bus.out_ready = 1'($urandom_range(0, 1));
    else bus.out_ready = (rmode == 1);
  endtask

  task automatic cycle();
    item_t o, e, ro;
    bit acc, hs, rdv, halt_now;
    halt_now = 1'b0;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    hs  = bus.out_valid && bus.out_ready;
    rdv = bus.redirect_valid;
    o = obs_item();
    if (stall_prev)
      chk("stable", {bus.out_valid, o}, {1'b1, prev_obs});
    chk("halted", bus.halted, m_halted);
    if (m_halted) chk("halt_in_ready", bus.in_ready, 1'b0);
    if (rdv) chk("redir_in_ready", bus.in_ready, 1'b0);
    if (bus.out_valid && first_ov < 0) first_ov = cyc;
    if (acc && first_acc < 0) first_acc = cyc;
    if (hs) begin
      hs_cnt++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      chk("out_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_item", o, e);
        if (e.cls == 3'd4 && !e.redir) halt_now = 1'b1;
      end
    end
    if (rdv) begin
      rd_cnt++;
      ro = '0;
      ro.redir = 1'b1;
      ro.pc = bus.redirect_pc;
      chk("redir_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("redirect", ro, e);
      end
      m_jmp = 1'b0;
    end
    if (acc) begin
      acc_cnt++;
      model_accept(src[0]);
    end
    if (halt_now) m_halted = 1'b1;
    stall_prev = bus.out_valid && !bus.out_ready;
    prev_obs = o;
    @(posedge clk);
    #1;
    cyc++;
    if (acc || (rdv && presented)) begin
      void'(src.pop_front());
      presented = 1'b0;
    end
    drive();
  endtask

  task automatic run_drain(int n);
    int k;
    k = 0;
    rmode = 1;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || src.size() != 0) && k < n) begin
      cycle();
      k++;
    end
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_src", src.size(), 0);
    chk("drain_idle", bus.out_valid, 1'b0);
  endtask

  task automatic clear_stats();
    acc_cnt = 0; hs_cnt = 0; rd_cnt = 0;
    first_acc = -1; first_ov = -1;
    first_hs = -1; last_hs = -1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    src.delete();
    exp_q.delete();
    presented = 1'b0;
    m_jmp = 1'b0; m_haltacc = 1'b0; m_halted = 1'b0;
    stall_prev = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_redirect", bus.redirect_valid, 1'b0);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_data", {bus.out_class, bus.out_imm, bus.out_pc}, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic word_t rand_word();
    logic [7:0] op;
    int p;
    p = $urandom_range(0, 7);
    case (p)
      0: op = 8'h00;
      1: op = 8'h01;
      2: op = 8'h02;
      3: op = 8'h10;
      4: op = 8'h11;
      5: op = 8'h7E;
      6: op = 8'($urandom_range(0, 254));
      default: op = 8'h01;
    endcase
    return mk(op, 8'($urandom), 8'($urandom), 8'($urandom),
              10'($urandom));
  endfunction

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr1 = '0; bus.in_instr2 = '0;
    bus.in_instr3 = '0; bus.in_instr4 = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;
    vmode = 1; rmode = 1;
    #2;
    do_reset();

    // back-to-back words, latency and throughput
    clear_stats();
    vmode = 1; rmode = 1;
    src.push_back(mk(8'h01, 8'h23, 8'h04, 8'h56, 10'h05C));
    src.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 10'h060));
    src.push_back(mk(8'h02, 8'h05, 8'h12, 8'h34, 10'h064));
    drive();
    run_drain(50);
    chk("latency", first_ov - first_acc, 1);
    chk("throughput", last_hs - first_hs, 2);
    chk("hs_count", hs_cnt, 3);

    // back-pressure: output stalled while fetch streams
    clear_stats();
    vmode = 1; rmode = 0;
    for (int i = 0; i < 5; i++)
      src.push_back(mk(8'h01, 8'(8'h20 + i), 8'(i), 8'h00,
                       10'(10'h080 + 4 * i)));
    drive();
    repeat (5) cycle();
    chk("stall_accepts", acc_cnt, 3);
    chk("stall_in_ready", bus.in_ready, 1'b0);
    run_drain(60);
    chk("stall_hs", hs_cnt, 5);

    // JMP with a younger ALU word behind it
    clear_stats();
    vmode = 1; rmode = 0;
    src.push_back(mk(8'h01, 8'h41, 8'h02, 8'h00, 10'h100));
    src.push_back(mk(8'h10, 8'h00, 8'h01, 8'h20, 10'h104));
    src.push_back(mk(8'h01, 8'h22, 8'h03, 8'h00, 10'h108));
    drive();
    repeat (4) cycle();
    chk("jmp_fill", acc_cnt, 3);
    run_drain(40);
    chk("jmp_redir_cnt", rd_cnt, 1);
    chk("jmp_hs", hs_cnt, 1);

    // illegal opcode, then a truncated redirect target
    clear_stats();
    vmode = 0; rmode = 1;
    src.push_back(mk(8'h7E, 8'h12, 8'h34, 8'h56, 10'h10C));
    src.push_back(mk(8'h01, 8'hA3, 8'h04, 8'h00, 10'h110));
    src.push_back(mk(8'h10, 8'h00, 8'hFE, 8'h34, 10'h114));
    drive();
    run_drain(60);
    chk("ill_hs", hs_cnt, 2);
    chk("trunc_redir_cnt", rd_cnt, 1);

    // random traffic with random back-pressure
    clear_stats();
    vmode = 0; rmode = 2;
    for (int i = 0; i < 400; i++) begin
      if (src.size() < 3) src.push_back(rand_word());
      cycle();
    end
    run_drain(300);

    // HALT stops intake until reset
    clear_stats();
    vmode = 1; rmode = 1;
    src.push_back(mk(8'h01, 8'h21, 8'h02, 8'h00, 10'h140));
    src.push_back(mk(8'hFF, 8'hAA, 8'hBB, 8'hCC, 10'h144));
    src.push_back(mk(8'h01, 8'h22, 8'h03, 8'h00, 10'h148));
    src.push_back(mk(8'h02, 8'h01, 8'h00, 8'h07, 10'h14C));
    drive();
    repeat (20) cycle();
    chk("halt_set", bus.halted, 1'b1);
    chk("halt_hs", hs_cnt, 2);
    chk("halt_exp_empty", exp_q.size(), 0);
    chk("halt_no_out", bus.out_valid, 1'b0);
    do_reset();

    // asynchronous reset with a full FIFO
    clear_stats();
    vmode = 1; rmode = 0;
    for (int i = 0; i < 4; i++)
      src.push_back(mk(8'h02, 8'(i), 8'h11, 8'(i), 10'(10'h180 + 4 * i)));
    drive();
    repeat (4) cycle();
    chk("prereset_full", bus.in_ready, 1'b0);
    @(negedge clk);
    #2;
    do_reset();
    clear_stats();
    vmode = 1; rmode = 1;
    src.push_back(mk(8'h02, 8'h07, 8'hAB, 8'hCD, 10'h200));
    drive();
    run_drain(40);
    chk("post_reset_hs", hs_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
